// File: rtl/trackball_quad_if.sv
// Trackball encoder bus: mouse sample inputs and per-axis step outputs.
// Optional pos_o present only when TRAK_POS_EN is defined.
interface trackball_quad_if #(
  parameter int AXES  = 2,
  parameter int DIV_W = 4
);
  logic                   strobe_i;
  logic [AXES*9-1:0]      delta_i;
  logic                   flip_i;
  logic [AXES-1:0]        inv_i;
  logic [DIV_W-1:0]       step_div_i;
  logic [AXES-1:0]        ph0_o;
  logic [AXES-1:0]        ph1_o;
  logic                   busy_o;
`ifdef TRAK_POS_EN
  logic [AXES*16-1:0]     pos_o;

  modport master (
    output strobe_i, delta_i, flip_i,
    output inv_i, step_div_i,
    input  ph0_o, ph1_o, busy_o, pos_o
  );
  modport slave (
    input  strobe_i, delta_i, flip_i,
    input  inv_i, step_div_i,
    output ph0_o, ph1_o, busy_o, pos_o
  );
`else
  modport master (
    output strobe_i, delta_i, flip_i,
    output inv_i, step_div_i,
    input  ph0_o, ph1_o, busy_o
  );
  modport slave (
    input  strobe_i, delta_i, flip_i,
    input  inv_i, step_div_i,
    output ph0_o, ph1_o, busy_o
  );
`endif
endinterface

// File: rtl/trackball_quad.sv
// Mouse-delta to trackball step encoder, N axes, dir+toggle or Gray.
// Ports: clk_sys, reset (sync, high), bus (trackball_quad_if.slave):
//   strobe_i/delta_i/flip_i/inv_i/step_div_i in; ph0_o/ph1_o/busy_o out.
// Macro TRAK_POS_EN adds bus.pos_o, a 16-bit position per axis.
module trackball_quad #(
  parameter int AXES      = 2,
  parameter int ACC_W     = 12,
  parameter int DIV_W     = 4,
  parameter int QUAD_MODE = 0
) (
  input logic             clk_sys,
  input logic             reset,
  trackball_quad_if.slave bus
);

  logic                        strobe_q;
  logic                        take;
  logic                        add_q;
  logic [DIV_W-1:0]            div_q;
  logic [DIV_W-1:0]            div_d;
  logic                        tick;
  logic [AXES-1:0][ACC_W-1:0]  acc_q;
  logic [AXES-1:0][ACC_W-1:0]  acc_d;
  logic [AXES-1:0][ACC_W-1:0]  dlt_q;
  logic [AXES-1:0][ACC_W-1:0]  dlt_d;
  logic [AXES-1:0]             sgn;
  logic [AXES-1:0]             nz;
  logic [AXES-1:0]             step;
  logic [AXES-1:0]             dir;
  logic [AXES-1:0]             ph0_q;
  logic [AXES-1:0]             ph1_q;
  logic [AXES-1:0]             ph0_d;
  logic [AXES-1:0]             ph1_d;
  logic                        busy_q;
`ifdef TRAK_POS_EN
  logic [AXES-1:0][15:0]       pos_q;
  logic [AXES-1:0][15:0]       pos_d;
`endif

  assign take = bus.strobe_i ^ strobe_q;

  always_comb begin
    tick = (div_q == bus.step_div_i);
    // A divider left above a lowered limit wraps silently.
    if (tick || (div_q > bus.step_div_i))
      div_d = '0;
    else
      div_d = div_q + DIV_W'(1);

    for (int n = 0; n < AXES; n++) begin
      sgn[n] = bus.delta_i[9*n+8] ^ bus.flip_i
             ^ bus.inv_i[n];
      dlt_d[n] = {{(ACC_W-9){sgn[n]}}, sgn[n],
                  bus.delta_i[9*n +: 8]};

      nz[n]   = (acc_q[n] != '0);
      step[n] = tick && nz[n];
      dir[n]  = ~acc_q[n][ACC_W-1];

      // Top two bits differing marks the saturation band.
      acc_d[n] = acc_q[n];
      if (add_q &&
          (acc_q[n][ACC_W-1] == acc_q[n][ACC_W-2]))
        acc_d[n] = acc_d[n] + dlt_q[n];
      if (step[n])
        acc_d[n] = dir[n] ? acc_d[n] - ACC_W'(1)
                          : acc_d[n] + ACC_W'(1);

      ph0_d[n] = ph0_q[n];
      ph1_d[n] = ph1_q[n];
      if (step[n]) begin
        if (QUAD_MODE != 0) begin
          // {A,B}: fwd 00-01-11-10, rev opposite.
          ph0_d[n] = dir[n] ? ph1_q[n] : ~ph1_q[n];
          ph1_d[n] = dir[n] ? ~ph0_q[n] : ph0_q[n];
        end else begin
          ph0_d[n] = dir[n];
          ph1_d[n] = ~ph1_q[n];
        end
      end

`ifdef TRAK_POS_EN
      pos_d[n] = pos_q[n];
      if (step[n])
        pos_d[n] = dir[n] ? pos_q[n] + 16'd1
                          : pos_q[n] - 16'd1;
`endif
    end
  end

  always_ff @(posedge clk_sys) begin
    strobe_q <= bus.strobe_i;
    if (reset) begin
      add_q  <= 1'b0;
      dlt_q  <= '0;
      div_q  <= '0;
      acc_q  <= '0;
      ph0_q  <= '0;
      ph1_q  <= '0;
      busy_q <= 1'b0;
`ifdef TRAK_POS_EN
      pos_q  <= '0;
`endif
    end else begin
      add_q  <= take;
      if (take)
        dlt_q <= dlt_d;
      div_q  <= div_d;
      acc_q  <= acc_d;
      ph0_q  <= ph0_d;
      ph1_q  <= ph1_d;
      busy_q <= |nz;
`ifdef TRAK_POS_EN
      pos_q  <= pos_d;
`endif
    end
  end

  assign bus.ph0_o  = ph0_q;
  assign bus.ph1_o  = ph1_q;
  assign bus.busy_o = busy_q;
`ifdef TRAK_POS_EN
  assign bus.pos_o  = pos_q;
`endif

endmodule
